// File: rtl/seq_ripple_adder_if.sv
// Handshake and data bundle for seq_ripple_adder.
//   master: drives start, a, b, carryIn; observes busy, done, sum, carry, ovf
//   slave : the adder side of the same signals
//   start   request an add (accepted in IDLE or DONE)
//   a, b    WIDTH-bit operands, captured with carryIn on the accepted start
//   busy    high while the add is in progress
//   done    one-cycle pulse; sum/carry/ovf valid from this cycle onward
//   sum     a + b + carryIn mod 2^WIDTH
//   carry   unsigned carry-out of the MSB
//   ovf     signed two's-complement overflow
interface seq_ripple_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  modport master (
    output start, a, b, carryIn,
    input  busy, done, sum, carry, ovf
  );

  modport slave (
    input  start, a, b, carryIn,
    output busy, done, sum, carry, ovf
  );
endinterface

// File: rtl/seq_ripple_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit operands plus a carry-in,
// CHUNK bits per clock, through an internal carry register.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset, highest priority
//   bus  seq_ripple_adder_if slave: start/a/b/carryIn in,
//        busy/done/sum/carry/ovf out
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one chunk added per clock, busy = 1
// DONE  | one-cycle done pulse; results just loaded; start accepted here too
module seq_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic               clk,
  input logic               rst,
  seq_ripple_adder_if.slave bus
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("seq_ripple_adder: WIDTH must be >= 2 and CHUNK must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wsum_q, wsum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             busy, done, accept;
  logic [31:0]      base;
  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] wsum_nx;

  // Chunk datapath: one CHUNK-bit add with carry per clock. The working sum
  // is a shift register filled from the top, so after NCHUNK steps chunk 0
  // has arrived at the LSB position.
  always_comb begin
    base    = 32'(cnt_q) * 32'(CHUNK);
    ca      = CHUNK'(a_q >> base);
    cb      = CHUNK'(b_q >> base);
    csum    = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, cy_q};
    wsum_nx = WIDTH'({csum[CHUNK-1:0], wsum_q} >> CHUNK);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    wsum_d  = wsum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = bus.start;
      end
      RUN: begin
        busy   = 1'b1;
        wsum_d = wsum_nx;
        cy_d   = csum[CHUNK];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = wsum_nx;
          carry_d = csum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (wsum_nx[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        done    = 1'b1;
        accept  = bus.start;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d = RUN;
      a_d     = bus.a;
      b_d     = bus.b;
      cy_d    = bus.carryIn;
      cnt_d   = '0;
      wsum_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      wsum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      wsum_q  <= wsum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seq_ripple_adder.sv
module tb_seq_ripple_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_ripple_adder_if #(.WIDTH(8))  bus();
  seq_ripple_adder_if #(.WIDTH(8))  bus_c8();
  seq_ripple_adder_if #(.WIDTH(8))  bus_c1();
  seq_ripple_adder_if #(.WIDTH(16)) bus_w16();

  seq_ripple_adder #(.WIDTH(8),  .CHUNK(2)) dut     (.clk(clk), .rst(rst), .bus(bus));
  seq_ripple_adder #(.WIDTH(8),  .CHUNK(8)) dut_c8  (.clk(clk), .rst(rst), .bus(bus_c8));
  seq_ripple_adder #(.WIDTH(8),  .CHUNK(1)) dut_c1  (.clk(clk), .rst(rst), .bus(bus_c1));
  seq_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut_w16 (.clk(clk), .rst(rst), .bus(bus_w16));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model for the main instance (WIDTH=8, CHUNK=2): results come
  // from plain integer addition; timing is "NCHUNK busy cycles, then done".
  int         m_left = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_sum  = '0;
  bit         m_carry = 1'b0, m_ovf = 1'b0;
  logic [7:0] p_sum  = '0;
  bit         p_carry = 1'b0, p_ovf = 1'b0;
  logic [8:0] m_t;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0;
      m_sum = '0; m_carry = 1'b0; m_ovf = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_done) begin
        m_sum = p_sum; m_carry = p_carry; m_ovf = p_ovf;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        m_t     = {1'b0, bus.a} + {1'b0, bus.b} + 9'(bus.carryIn);
        p_sum   = m_t[7:0];
        p_carry = m_t[8];
        p_ovf   = (bus.a[7] == bus.b[7]) && (m_t[7] != bus.a[7]);
        m_left  = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",  32'(bus.busy),  32'(m_left > 0));
      chk("cyc_done",  32'(bus.done),  32'(m_done));
      chk("cyc_sum",   32'(bus.sum),   32'(m_sum));
      chk("cyc_carry", 32'(bus.carry), 32'(m_carry));
      chk("cyc_ovf",   32'(bus.ovf),   32'(m_ovf));
    end
  end

  task automatic start_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
    bus.a = ta; bus.b = tb_v; bus.carryIn = tc; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [7:0] es,
                           input logic ec, input logic eo);
    int n;
    int nb;
    n = 0; nb = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"},   32'(n),  32'(exp_lat));
    chk({name, "_busy"},  32'(nb), 32'(exp_lat));
    chk({name, "_sum"},   32'(bus.sum),   32'(es));
    chk({name, "_carry"}, 32'(bus.carry), 32'(ec));
    chk({name, "_ovf"},   32'(bus.ovf),   32'(eo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int dc;
    int l8, l1, l16;
    logic [7:0]  s8, s1;
    logic [15:0] s16;
    logic        c8, c1, c16, o8, o1, o16;

    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carryIn = 1'b0;
    bus_c8.start = 1'b0;  bus_c8.a = '0;  bus_c8.b = '0;  bus_c8.carryIn = 1'b0;
    bus_c1.start = 1'b0;  bus_c1.a = '0;  bus_c1.b = '0;  bus_c1.carryIn = 1'b0;
    bus_w16.start = 1'b0; bus_w16.a = '0; bus_w16.b = '0; bus_w16.carryIn = 1'b0;
    s8 = '0; s1 = '0; s16 = '0; c8 = 0; c1 = 0; c16 = 0; o8 = 0; o1 = 0; o16 = 0;

    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(bus.busy),  0);
    chk("rst_done",  32'(bus.done),  0);
    chk("rst_sum",   32'(bus.sum),   0);
    chk("rst_carry", 32'(bus.carry), 0);
    chk("rst_ovf",   32'(bus.ovf),   0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    start_add(8'h0F, 8'h01, 1'b0); wait_done("t0f_01", 4, 8'h10, 1'b0, 1'b0); @(negedge clk);
    start_add(8'hFF, 8'h01, 1'b0); wait_done("tff_01", 4, 8'h00, 1'b1, 1'b0); @(negedge clk);
    start_add(8'h00, 8'h00, 1'b1); wait_done("t00_ci", 4, 8'h01, 1'b0, 1'b0); @(negedge clk);
    start_add(8'h7F, 8'h01, 1'b0); wait_done("t7f_01", 4, 8'h80, 1'b0, 1'b1); @(negedge clk);
    start_add(8'h80, 8'h80, 1'b0); wait_done("t80_80", 4, 8'h00, 1'b1, 1'b1); @(negedge clk);
    start_add(8'hFF, 8'hFF, 1'b1); wait_done("tff_ff", 4, 8'hFF, 1'b1, 1'b0); @(negedge clk);

    // start and operand changes during RUN are ignored
    start_add(8'h12, 8'h34, 1'b0);
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore", 2, 8'h46, 1'b0, 1'b0);
    dc = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    chk("hold_extra_done", 32'(dc), 0);
    chk("hold_sum", 32'(bus.sum), 32'h46);

    // back-to-back: start asserted in the DONE cycle
    start_add(8'h20, 8'h22, 1'b0);
    wait_done("b2b_first", 4, 8'h42, 1'b0, 1'b0);
    start_add(8'h01, 8'h02, 1'b0);
    chk("b2b_busy_rise", 32'(bus.busy), 1);
    chk("b2b_hold_first", 32'(bus.sum), 32'h42);
    wait_done("b2b_second", 4, 8'h03, 1'b0, 1'b0);
    @(negedge clk);

    // reset on the second RUN cycle discards the add
    start_add(8'h55, 8'h11, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy",  32'(bus.busy),  0);
    chk("mid_rst_done",  32'(bus.done),  0);
    chk("mid_rst_sum",   32'(bus.sum),   0);
    chk("mid_rst_carry", 32'(bus.carry), 0);
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    chk("mid_rst_no_done", 32'(dc), 0);

    // parameter sweep: all three variants started together
    bus_c8.a  = 8'hFF;    bus_c8.b  = 8'h01;
    bus_c1.a  = 8'hFF;    bus_c1.b  = 8'h01;
    bus_w16.a = 16'hFFFF; bus_w16.b = 16'h0001;
    bus_c8.start = 1'b1; bus_c1.start = 1'b1; bus_w16.start = 1'b1;
    @(negedge clk);
    bus_c8.start = 1'b0; bus_c1.start = 1'b0; bus_w16.start = 1'b0;
    l8 = -1; l1 = -1; l16 = -1;
    for (int n = 0; n < 20; n++) begin
      if (bus_c8.done && l8 < 0) begin
        l8 = n; s8 = bus_c8.sum; c8 = bus_c8.carry; o8 = bus_c8.ovf;
      end
      if (bus_c1.done && l1 < 0) begin
        l1 = n; s1 = bus_c1.sum; c1 = bus_c1.carry; o1 = bus_c1.ovf;
      end
      if (bus_w16.done && l16 < 0) begin
        l16 = n; s16 = bus_w16.sum; c16 = bus_w16.carry; o16 = bus_w16.ovf;
      end
      @(negedge clk);
    end
    chk("c8_lat",    32'(l8), 1);
    chk("c8_sum",    32'(s8), 0);
    chk("c8_carry",  32'(c8), 1);
    chk("c8_ovf",    32'(o8), 0);
    chk("c1_lat",    32'(l1), 8);
    chk("c1_sum",    32'(s1), 0);
    chk("c1_carry",  32'(c1), 1);
    chk("c1_ovf",    32'(o1), 0);
    chk("w16_lat",   32'(l16), 4);
    chk("w16_sum",   32'(s16), 0);
    chk("w16_carry", 32'(c16), 1);
    chk("w16_ovf",   32'(o16), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
